// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes,
// instruction layout and sequencer FSM encoding.
package calc_pkg;

   // Datapath and instruction geometry (the calculator fixes these)
   localparam int CALC_DATA_W  = 8;
   localparam int CALC_INSTR_W = 22;
   localparam int CTRL_W       = 4;
   localparam int REG_W        = 3;

   // Instruction field offsets (LSB positions inside the packed word)
   localparam int CTRL_LSB = 18;
   localparam int RW_LSB   = 15;
   localparam int RX_LSB   = 12;
   localparam int RY_LSB   = 9;
   localparam int SEL_BIT  = 8;
   localparam int IMM_LSB  = 0;

   // Calculator ALU opcodes; codes 0xD-0xF are undefined and forwarded as-is
   typedef enum logic [CTRL_W-1:0] {
      CTRL_ADD = 4'h0,
      CTRL_SUB = 4'h1,
      CTRL_AND = 4'h2,
      CTRL_OR  = 4'h3,
      CTRL_XOR = 4'h4,
      CTRL_NOT = 4'h5,
      CTRL_SHL = 4'h6,
      CTRL_SHR = 4'h7,
      CTRL_ROL = 4'h8,
      CTRL_ROR = 4'h9,
      CTRL_INC = 4'hA,
      CTRL_DEC = 4'hB,
      CTRL_EQ  = 4'hC
   } ctrl_e;

   // Packed view of an instruction word; field order matches the bit layout
   typedef struct packed {
      logic [CTRL_W-1:0]      ctrl;
      logic [REG_W-1:0]       rw;
      logic [REG_W-1:0]       rx;
      logic [REG_W-1:0]       ry;
      logic                   sel;
      logic [CALC_DATA_W-1:0] imm;
   } instr_t;

   // Sequencer states: one instruction walks IDLE -> EXEC -> READ -> RESP
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_READ = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/calc_instr_fifo.sv
// Instruction buffer: synchronous FIFO with one extra pointer bit so that
// full and empty are told apart without a separate occupancy counter.
module calc_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Same index with differing wrap bits means the writer lapped the reader
   assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   // A full FIFO refuses a push even if the head leaves on the same edge
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[IDX_W-1:0]];

   // Pointer update; reset empties the buffer immediately
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; the pointers alone decide which
      // entries are valid, so stale contents are never observed.
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/calc_sequencer.sv
// Command front-end for simple_calculator: buffers instruction words,
// issues each as a write cycle, reads the destination back on port Y and
// returns {carry, result} over a valid/ready response stream.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = CALC_DATA_W,
   parameter int INSTR_W    = CALC_INSTR_W
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W:0]    out_data,
   output logic [7:0]         resp_cnt,
   output logic               WEN,
   output logic [2:0]         RW,
   output logic [2:0]         RX,
   output logic [2:0]         RY,
   output logic [DATA_W-1:0]  DataIn,
   output logic               Sel,
   output logic [3:0]         Ctrl,
   input  logic [DATA_W-1:0]  busY,
   input  logic               Carry
);

   state_t             state;
   state_t             state_nxt;
   instr_t             instr_q;
   logic [INSTR_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               handshake;
   logic               carry_q;
   logic [DATA_W-1:0]  result_q;

   // in_ready is held low for the whole reset window, not just by full
   assign in_ready  = !fifo_full && !Rst;
   assign push      = in_valid && in_ready;
   // The head is taken only when the sequencer is free for a new instruction
   assign pop       = (state == ST_IDLE) && !fifo_empty;
   assign handshake = out_valid && out_ready;

   calc_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk       (Clk),
      .rst       (Rst),
      .push      (push),
      .push_data (in_instr),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // FSM state register; reset returns to IDLE at once so WEN drops immediately
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Datapath registers: current instruction, captured carry/result, response count
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         instr_q  <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         resp_cnt <= '0;
      end else begin
         if (pop) instr_q <= instr_t'(fifo_head);
         // Carry belongs to the write cycle, result to the read-back cycle
         if (state == ST_EXEC) carry_q  <= Carry;
         if (state == ST_READ) result_q <= busY;
         if (handshake)        resp_cnt <= resp_cnt + 8'd1;
      end
   end

   // Next-state logic and output decode for the calculator and response ports
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_nxt = state;
      WEN       = 1'b0;
      RW        = '0;
      RX        = '0;
      RY        = '0;
      DataIn    = '0;
      Sel       = 1'b0;
      Ctrl      = '0;
      out_valid = 1'b0;
      out_data  = '0;

      case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            // Issue the operation; the calculator writes RW at the closing edge
            Ctrl      = instr_q.ctrl;
            RW        = instr_q.rw;
            RX        = instr_q.rx;
            RY        = instr_q.ry;
            Sel       = instr_q.sel;
            DataIn    = instr_q.imm;
            WEN       = 1'b1;
            state_nxt = ST_READ;
         end
         ST_READ: begin
            // Point read port Y at the register just written; no second write
            Ctrl      = instr_q.ctrl;
            RW        = instr_q.rw;
            RX        = instr_q.rx;
            RY        = instr_q.rw;
            Sel       = instr_q.sel;
            DataIn    = instr_q.imm;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            out_valid = 1'b1;
            out_data  = {carry_q, result_q};
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
